// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS datapath: sequences memory, ALU, register
// file and PC through FETCH/DECODE/EXEC/MEM/WB, halting on bad encodings or memory stalls.
module multicycle_controller #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic [2:0]  state,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        target_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        retired,
    output logic        illegal,
    output logic        timeout
);
    localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;
    localparam logic [1:0] DST_RT    = 2'd0;
    localparam logic [1:0] DST_RD    = 2'd1;
    localparam logic [1:0] DST_RA    = 2'd2;
    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_JALR, C_ILL
    } cls_t;

    state_t     state_q, state_d;
    cls_t       cls;
    logic [3:0] dec_alu_op;
    logic [1:0] dec_alu_src_b;
    logic       taken;
    logic [7:0] wait_cnt;
    logic       waiting;
    logic       wait_expire;
    logic       illegal_q, timeout_q;

    logic [5:0] opcode, funct;
    logic [4:0] rt;
    logic       unused_bits;

    assign opcode      = instruction[31:26];
    assign funct       = instruction[5:0];
    assign rt          = instruction[20:16];
    assign unused_bits = ^{instruction[25:21], instruction[15:6]};

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

    // A stalled memory cycle that would bring the wait count up to MAX_WAIT aborts instead.
    assign waiting     = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    assign wait_expire = waiting && ({1'b0, wait_cnt} + 9'd1 == WAIT_LIMIT);

    // Instruction class, ALU controls and branch outcome
    always_comb begin
        cls           = C_ILL;
        dec_alu_op    = ALU_ADD;
        dec_alu_src_b = SRCB_RT;
        taken         = 1'b0;
        case (opcode)
            6'h00: begin
                cls = C_RALU;
                case (funct)
                    6'h20, 6'h21: dec_alu_op = ALU_ADD;
                    6'h22, 6'h23: dec_alu_op = ALU_SUB;
                    6'h24:        dec_alu_op = ALU_AND;
                    6'h25:        dec_alu_op = ALU_OR;
                    6'h26:        dec_alu_op = ALU_XOR;
                    6'h27:        dec_alu_op = ALU_NOR;
                    6'h2A:        dec_alu_op = ALU_SLT;
                    6'h00:        dec_alu_op = ALU_SLL;
                    6'h02:        dec_alu_op = ALU_SRL;
                    6'h03:        dec_alu_op = ALU_SRA;
                    6'h08:        cls = C_JR;
                    6'h09:        cls = C_JALR;
                    default:      cls = C_ILL;
                endcase
            end
            6'h01: begin
                if (rt == 5'd0) begin
                    cls        = C_BR;
                    dec_alu_op = ALU_SUB;
                    taken      = alu_neg;
                end
            end
            6'h02: cls = C_J;
            6'h03: cls = C_JAL;
            6'h04: begin cls = C_BR; dec_alu_op = ALU_SUB; taken = alu_zero; end
            6'h05: begin cls = C_BR; dec_alu_op = ALU_SUB; taken = !alu_zero; end
            6'h06: begin cls = C_BR; dec_alu_op = ALU_SUB; taken = alu_zero || alu_neg; end
            6'h07: begin cls = C_BR; dec_alu_op = ALU_SUB; taken = !alu_zero && !alu_neg; end
            6'h08, 6'h09: begin cls = C_IALU; dec_alu_op = ALU_ADD;  dec_alu_src_b = SRCB_SEXT; end
            6'h0A: begin cls = C_IALU; dec_alu_op = ALU_SLT;  dec_alu_src_b = SRCB_SEXT; end
            6'h0B: begin cls = C_IALU; dec_alu_op = ALU_SLTU; dec_alu_src_b = SRCB_SEXT; end
            6'h0C: begin cls = C_IALU; dec_alu_op = ALU_AND;  dec_alu_src_b = SRCB_ZEXT; end
            6'h0F: begin cls = C_IALU; dec_alu_op = ALU_LUI;  dec_alu_src_b = SRCB_ZEXT; end
            6'h23: begin cls = C_LW;   dec_alu_op = ALU_ADD;  dec_alu_src_b = SRCB_SEXT; end
            6'h2B: begin cls = C_SW;   dec_alu_op = ALU_ADD;  dec_alu_src_b = SRCB_SEXT; end
            default: cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt  <= waiting ? wait_cnt + 8'd1 : 8'd0;
            illegal_q <= illegal_q || (state_q == S_DECODE && cls == C_ILL);
            timeout_q <= timeout_q || wait_expire;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (wait_expire) state_d = S_HALT;
            end
            S_DECODE: state_d = (cls == C_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_RALU, C_IALU: state_d = S_WB;
                    C_LW, C_SW:     state_d = S_MEM;
                    C_ILL:          state_d = S_HALT;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)        state_d = (cls == C_LW) ? S_WB : S_FETCH;
                else if (wait_expire) state_d = S_HALT;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    // Datapath strobes and selects; everything is forced low while reset is held
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        target_write = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = DST_RT;
        wb_src       = WB_ALU;
        alu_src_b    = SRCB_RT;
        alu_op       = ALU_ADD;
        pc_src       = PC_SEQ;
        retired      = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = !wait_expire;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SEQ;
                    end
                end
                S_DECODE: target_write = 1'b1;
                S_EXEC: begin
                    alu_op    = dec_alu_op;
                    alu_src_b = dec_alu_src_b;
                    case (cls)
                        C_BR: begin
                            retired = 1'b1;
                            if (taken) begin
                                pc_write = 1'b1;
                                pc_src   = PC_BRANCH;
                            end
                        end
                        C_J, C_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                            retired  = 1'b1;
                            if (cls == C_JAL) begin
                                reg_write = 1'b1;
                                reg_dst   = DST_RA;
                                wb_src    = WB_PC;
                            end
                        end
                        C_JR, C_JALR: begin
                            pc_write = 1'b1;
                            pc_src   = PC_RS;
                            retired  = 1'b1;
                            if (cls == C_JALR) begin
                                reg_write = 1'b1;
                                reg_dst   = DST_RD;
                                wb_src    = WB_PC;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    alu_op    = ALU_ADD;
                    alu_src_b = SRCB_SEXT;
                    mem_read  = (cls == C_LW) && !wait_expire;
                    mem_write = (cls == C_SW) && !wait_expire;
                    retired   = (cls == C_SW) && mem_ready;
                end
                S_WB: begin
                    alu_op    = dec_alu_op;
                    alu_src_b = dec_alu_src_b;
                    reg_write = 1'b1;
                    retired   = 1'b1;
                    reg_dst   = (cls == C_RALU) ? DST_RD : DST_RT;
                    wb_src    = (cls == C_LW) ? WB_MEM : WB_ALU;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions checked cycle by
// cycle against an instruction-level model of the expected control sequence.
module tb_multicycle_controller;
    localparam int unsigned MAX_WAIT = 15;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd7;
    localparam logic [5:0] OPS [16] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23, 6'h2B};
    localparam logic [5:0] FNS [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                        6'h27, 6'h00, 6'h02, 6'h03, 6'h2A, 6'h08, 6'h09};

    typedef enum int {K_RALU, K_IALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_JALR, K_ILL} kind_t;

    typedef struct packed {
        logic [2:0] st;
        logic       mr, mw, irw, pcw, tw, rw;
        logic [1:0] rd, wbs, asb;
        logic [3:0] aop;
        logic [1:0] pcs;
        logic       ret, ill, tmo;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        mem_ready, alu_zero, alu_neg;
    logic [2:0]  state;
    logic        mem_read, mem_write, ir_write, pc_write, target_write, reg_write;
    logic [1:0]  reg_dst, wb_src, alu_src_b, pc_src;
    logic [3:0]  alu_op;
    logic        retired, illegal, timeout;

    always #5 clk = ~clk;

    multicycle_controller #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .state(state), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .target_write(target_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .wb_src(wb_src), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .retired(retired), .illegal(illegal), .timeout(timeout)
    );

    obs_t obs;
    assign obs = {state, mem_read, mem_write, ir_write, pc_write, target_write, reg_write,
                  reg_dst, wb_src, alu_src_b, alu_op, pc_src, retired, illegal, timeout};

    int   checks = 0;
    int   errors = 0;
    logic ill_m  = 1'b0;
    logic tmo_m  = 1'b0;
    obs_t exp_q[$];
    logic rdy_q[$];

    // Instruction class and ALU controls straight from the supported-instruction table
    function automatic kind_t classify(input logic [31:0] ins, output logic [3:0] aop,
                                       output logic [1:0] asb);
        kind_t k;
        k = K_ILL; aop = 4'd0; asb = 2'd0;
        case (ins[31:26])
            6'h00: begin
                k = K_RALU;
                case (ins[5:0])
                    6'h20, 6'h21: aop = 4'd0;
                    6'h22, 6'h23: aop = 4'd1;
                    6'h24: aop = 4'd2;
                    6'h25: aop = 4'd3;
                    6'h26: aop = 4'd4;
                    6'h27: aop = 4'd5;
                    6'h2A: aop = 4'd6;
                    6'h00: aop = 4'd8;
                    6'h02: aop = 4'd9;
                    6'h03: aop = 4'd10;
                    6'h08: k = K_JR;
                    6'h09: k = K_JALR;
                    default: k = K_ILL;
                endcase
            end
            6'h01: if (ins[20:16] == 5'd0) begin k = K_BR; aop = 4'd1; end
            6'h04, 6'h05, 6'h06, 6'h07: begin k = K_BR; aop = 4'd1; end
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            6'h08, 6'h09: begin k = K_IALU; aop = 4'd0; asb = 2'd2; end
            6'h0A: begin k = K_IALU; aop = 4'd6;  asb = 2'd2; end
            6'h0B: begin k = K_IALU; aop = 4'd7;  asb = 2'd2; end
            6'h0C: begin k = K_IALU; aop = 4'd2;  asb = 2'd3; end
            6'h0F: begin k = K_IALU; aop = 4'd11; asb = 2'd3; end
            6'h23: begin k = K_LW;   aop = 4'd0;  asb = 2'd2; end
            6'h2B: begin k = K_SW;   aop = 4'd0;  asb = 2'd2; end
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    // Branch outcome from the rs-rt difference, as a signed comparison
    function automatic bit is_taken(input logic [5:0] op, input logic [31:0] diff);
        case (op)
            6'h04:   return diff == 32'd0;
            6'h05:   return diff != 32'd0;
            6'h06:   return $signed(diff) <= 0;
            6'h07:   return $signed(diff) > 0;
            default: return $signed(diff) < 0;
        endcase
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t o;
        o = '0; o.st = st; o.ill = ill_m; o.tmo = tmo_m;
        return o;
    endfunction

    task automatic push(input obs_t o, input logic r);
        exp_q.push_back(o);
        rdy_q.push_back(r);
    endtask

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // Expected per-cycle sequence for one instruction with the given memory stalls
    task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic [31:0] diff);
        obs_t o;
        kind_t k;
        logic [3:0] aop;
        logic [1:0] asb;
        k = classify(ins, aop, asb);
        for (int i = 0; i < fw; i++) begin o = blank(S_F); o.mr = 1'b1; push(o, 1'b0); end
        o = blank(S_F); o.mr = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; push(o, 1'b1);
        o = blank(S_D); o.tw = 1'b1; push(o, rnd());
        if (k == K_ILL) begin
            ill_m = 1'b1;
            for (int i = 0; i < 3; i++) push(blank(S_H), rnd());
            return;
        end
        o = blank(S_E); o.aop = aop; o.asb = asb;
        case (k)
            K_BR: begin o.ret = 1'b1; if (is_taken(ins[31:26], diff)) begin o.pcw = 1'b1; o.pcs = 2'd1; end end
            K_J:    begin o.pcw = 1'b1; o.pcs = 2'd2; o.ret = 1'b1; end
            K_JAL:  begin o.pcw = 1'b1; o.pcs = 2'd2; o.ret = 1'b1; o.rw = 1'b1; o.rd = 2'd2; o.wbs = 2'd2; end
            K_JR:   begin o.pcw = 1'b1; o.pcs = 2'd3; o.ret = 1'b1; end
            K_JALR: begin o.pcw = 1'b1; o.pcs = 2'd3; o.ret = 1'b1; o.rw = 1'b1; o.rd = 2'd1; o.wbs = 2'd2; end
            default: ;
        endcase
        push(o, rnd());
        if (k == K_LW || k == K_SW) begin
            o = blank(S_M); o.aop = 4'd0; o.asb = 2'd2;
            o.mr = (k == K_LW); o.mw = (k == K_SW);
            for (int i = 0; i < mw; i++) push(o, 1'b0);
            o.ret = (k == K_SW);
            push(o, 1'b1);
        end
        if (k == K_RALU || k == K_IALU || k == K_LW) begin
            o = blank(S_W); o.aop = aop; o.asb = asb; o.rw = 1'b1; o.ret = 1'b1;
            o.rd  = (k == K_RALU) ? 2'd1 : 2'd0;
            o.wbs = (k == K_LW) ? 2'd1 : 2'd0;
            push(o, rnd());
        end
    endtask

    task automatic trunc(input int n);
        while (exp_q.size() > n) begin
            void'(exp_q.pop_back());
            void'(rdy_q.pop_back());
        end
    endtask

    // Drive each cycle's mem_ready, compare just after, then move past the next edge
    task automatic play(input string tag);
        obs_t e;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            #1;
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s[%0d] observed=%h expected=%h", tag, cyc, obs, e);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        obs_t o;
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        o = obs; o.st = '0; o.ill = 1'b0; o.tmo = 1'b0;
        checks++;
        assert (o === obs_t'(0)) else begin
            errors++;
            $error("FAIL reset_strobes observed=%h expected=%h", o, obs_t'(0));
        end
        @(negedge clk);
        ill_m = 1'b0; tmo_m = 1'b0;
        #1;
        checks++;
        assert (obs === blank(S_F)) else begin
            errors++;
            $error("FAIL reset_state observed=%h expected=%h", obs, blank(S_F));
        end
        reset = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input int fw, input int mw,
                       input logic [31:0] diff);
        instruction = ins;
        alu_zero    = (diff == 32'd0);
        alu_neg     = diff[31];
        build(ins, fw, mw, diff);
        play(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0) return w;
        w[31:26] = OPS[$urandom_range(0, 15)];
        if (w[31:26] == 6'h00) w[5:0] = FNS[$urandom_range(0, 13)];
        if (w[31:26] == 6'h01 && r != 1) w[20:16] = 5'd0;
        return w;
    endfunction

    initial begin
        obs_t o;
        logic [31:0] w;
        logic [31:0] d;
        instruction = 32'h0; alu_zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b1;
        do_reset();

        run("add", 32'h00221820, 0, 0, 32'd7);
        run("lw_wait3", 32'h8C220008, 0, 3, 32'd1);
        run("beq_taken", 32'h10220003, 0, 0, 32'd0);
        run("beq_not", 32'h10220003, 0, 0, 32'd5);
        run("jal", 32'h0C000010, 0, 0, 32'd3);
        run("sw_fetchwait", 32'hAC220004, 2, 1, 32'd3);
        run("bltz_neg", 32'h04200002, 1, 0, 32'hFFFF_FFF0);
        run("blez_neg", 32'h18200002, 0, 0, 32'h8000_0000);
        run("bgtz_pos", 32'h1C200002, 0, 0, 32'h0000_0001);
        run("lui", 32'h3C011234, 0, 0, 32'd0);
        run("jalr", 32'h0020F809, 0, 0, 32'd0);
        run("lw_maxwait", 32'h8C220008, MAX_WAIT - 1, MAX_WAIT - 1, 32'd0);

        run("ill_opcode", 32'hFC000000, 0, 0, 32'd0);
        do_reset();
        run("ill_funct", 32'h00000018, 0, 0, 32'd0);
        do_reset();
        run("ill_bltz_rt", 32'h04010002, 0, 0, 32'd0);
        do_reset();

        // Fetch stall that hits the limit: no read strobe in the aborting cycle
        instruction = 32'h00221820;
        build(instruction, MAX_WAIT - 1, 0, 32'd0);
        trunc(MAX_WAIT - 1);
        push(blank(S_F), 1'b0);
        tmo_m = 1'b1;
        for (int i = 0; i < 3; i++) push(blank(S_H), rnd());
        play("fetch_timeout");
        do_reset();

        // Store stall that hits the limit in MEM
        instruction = 32'hAC220004;
        build(instruction, 0, MAX_WAIT - 1, 32'd0);
        trunc(exp_q.size() - 1);
        o = blank(S_M); o.aop = 4'd0; o.asb = 2'd2;
        push(o, 1'b0);
        tmo_m = 1'b1;
        for (int i = 0; i < 3; i++) push(blank(S_H), rnd());
        play("mem_timeout");
        do_reset();

        // Reset asserted while a jal sits in EXEC
        instruction = 32'h0C000010;
        build(instruction, 0, 0, 32'd0);
        trunc(2);
        play("jal_pre_reset");
        do_reset();
        run("after_reset", 32'h00221820, 0, 0, 32'd0);

        for (int n = 0; n < 60; n++) begin
            w = rand_instr();
            d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run("random", w, $urandom_range(0, 3), $urandom_range(0, 3), d);
            if (ill_m) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle MIPS datapath. It sequences the shared memory port, ALU, register file and PC through the FETCH/DECODE/EXEC/MEM/WB steps for the supported instruction set.
- It decodes the same opcode and funct fields the debugger prints, and emits per-cycle datapath strobes and mux selects.
- It halts on an illegal encoding or on a memory-wait timeout.

Parameters:
- MAX_WAIT, 15: maximum consecutive cycles the FSM waits with mem_ready low in FETCH or MEM before entering HALT. Range 1..255.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- instruction  in  32  IR contents; valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- alu_zero  in  1  ALU result (rs - rt) == 0
- alu_neg  in  1  ALU result (rs - rt) bit 31
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 HALT
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- pc_write  out  1  load PC from the pc_src mux
- target_write  out  1  latch the branch target (PC+4 + sext(imm)<<2)
- reg_write  out  1  register file write
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- wb_src  out  2  0 ALU result, 1 memory data, 2 PC (already +4)
- alu_src_b  out  2  0 rt, 1 constant 4, 2 sign-extended imm16, 3 zero-extended imm16
- alu_op  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sra, 11 lui
- pc_src  out  2  0 PC+4, 1 branch target, 2 {PC[31:28], JT, 00}, 3 rs
- retired  out  1  one-cycle pulse per completed instruction
- illegal  out  1  sticky; unsupported encoding seen
- timeout  out  1  sticky; MAX_WAIT exceeded

Behaviour:
- Reset:
  - Synchronous; overrides everything, including mid-instruction.
  - While reset=1, all strobes are 0. On the next edge: state=FETCH, illegal=0, timeout=0, wait counter=0.
- Output timing:
  - Strobes and selects are combinational from state, instruction and inputs.
  - Unused selects drive 0.
- FETCH:
  - Assert mem_read.
  - On mem_ready: ir_write=1, pc_write=1 with pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Always one cycle; target_write=1.
  - Supported opcodes: R-type, lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, bne, blez, bgtz, j, jal, and bltz (opcode 000001, rt=0 only).
  - Supported R-type funct: add, addu, sub, subu, and, or, xor, nor, sll, srl, sra, slt, jr, jalr.
  - Any other encoding: illegal=1, go to HALT. Otherwise go to EXEC.
- EXEC, by instruction class:
  - ALU R-type and I-type: drive alu_op/alu_src_b (andi uses zero-ext; addi, addiu, slti, sltiu, lw, sw use sign-ext). Go to WB; loads and stores go to MEM.
  - Branches: alu_op=sub, alu_src_b=0.
    - Taken conditions: beq=zero, bne=!zero, blez=zero|neg, bgtz=!zero&!neg, bltz=neg.
    - If taken: pc_write=1, pc_src=1.
    - retired=1, go to FETCH.
  - j: pc_write=1, pc_src=2, retired=1, go to FETCH.
  - jal: same as j, plus reg_write=1, reg_dst=2, wb_src=2.
  - jr: pc_write=1, pc_src=3, retired=1, go to FETCH.
  - jalr: same as jr, plus reg_write=1, reg_dst=1, wb_src=2.
- MEM:
  - lw asserts mem_read; sw asserts mem_write. alu_op=add and alu_src_b=2 are held throughout.
  - On mem_ready: sw gives retired=1 and goes to FETCH; lw goes to WB.
- WB:
  - reg_write=1 and retired=1, then go to FETCH.
  - lw: reg_dst=0, wb_src=1. R-type: reg_dst=1, wb_src=0. I-type ALU: reg_dst=0, wb_src=0.
  - ALU selects are held from EXEC.
- Latency (cycles, zero-wait memory):
  - R-type / I-type ALU: 4
  - lw: 5
  - sw: 4
  - branch / j / jal / jr / jalr: 3
  - Each FETCH or MEM wait cycle adds 1.
- Wait counter:
  - 8 bits. Increments on each FETCH/MEM cycle with mem_ready=0; clears on mem_ready or on leaving the state.
  - When it would reach MAX_WAIT: timeout=1, go to HALT, with no strobe in that cycle.
- mem_ready in other states: ignored.
- HALT: all strobes 0; stays in HALT until reset.

Test Plan:
- Reset with mem_ready=1, then feed add $3,$1,$2 (0x00221820) → states 0,1,2,4,0. ir_write and pc_write high in cycle 1; WB has reg_write=1, reg_dst=1, alu_op=0, retired=1.
- lw $2,8($1) (0x8C220008) with mem_ready low for 3 MEM cycles → MEM held 4 cycles with mem_read=1 and alu_src_b=2. WB has wb_src=1, reg_dst=0. Total 8 cycles.
- beq (0x10220003) with alu_zero=1 → EXEC pc_write=1, pc_src=1. Repeat with alu_zero=0 → pc_write=0. Both retire in 3 cycles.
- jal 0x0C000010 → EXEC has reg_write=1, reg_dst=2, wb_src=2, pc_src=2, retired=1. Then back to FETCH.
- Opcode 0x3F (0xFC000000), then funct 0x18 (0x00000018) → DECODE sets illegal=1, state=7, all strobes 0 until reset.
- mem_ready held 0 in FETCH with MAX_WAIT=15 → timeout=1 and HALT on the 15th wait cycle. Assert reset mid-EXEC of a second run → FETCH next cycle with illegal and timeout cleared.
